// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_addsub_if : operand/result handshake bundle for pipelined_addsub
// rev 1.0
// ----------------------------------------------------------------------------
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, Cout, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, Cout, Ovf, Zero
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_addsub : STAGES-deep chunked ripple add/sub with valid/ready flow
// rev 1.0
// ----------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipelined_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;

  // Per-stage token: operands (skewed), partial sum (deskewed), chunk carry.
  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic              r_ovf;
  logic              r_zero;

  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_src_v;
  logic [WIDTH-1:0]  w_src_a [STAGES];
  logic [WIDTH-1:0]  w_src_b [STAGES];
  logic [WIDTH-1:0]  w_src_s [STAGES];
  logic [STAGES-1:0] w_src_c;
  logic [CHUNK:0]    w_sum   [STAGES];
  logic [WIDTH-1:0]  w_nxt_s [STAGES];
  logic [STAGES-1:0] w_nxt_c;
  logic              w_ovf;
  logic              w_zero;

  // A stage can load when it is empty or its token moves on this cycle.
  always_comb begin : p_ready
    logic w_chain;
    w_rdy        = '0;
    w_chain      = !r_v[LAST] || bus.out_ready;
    w_rdy[LAST]  = w_chain;
    for (int k = LAST - 1; k >= 0; k--) begin
      w_chain  = !r_v[k] || w_chain;
      w_rdy[k] = w_chain;
    end
  end

  always_comb begin : p_datapath
    int p;
    p       = 0;
    w_src_v = '0;
    w_src_c = '0;
    w_nxt_c = '0;
    w_src_a = '{default: '0};
    w_src_b = '{default: '0};
    w_src_s = '{default: '0};
    w_sum   = '{default: '0};
    w_nxt_s = '{default: '0};
    for (int k = 0; k < STAGES; k++) begin
      p = (k == 0) ? 0 : k - 1;
      // Stage 0 takes the transformed operands; later stages take the upstream token.
      w_src_v[k] = (k == 0) ? bus.in_valid : r_v[p];
      w_src_a[k] = (k == 0) ? bus.A : r_a[p];
      w_src_b[k] = (k == 0) ? (bus.Sub ? ~bus.B : bus.B) : r_b[p];
      w_src_c[k] = (k == 0) ? (bus.Sub ^ bus.Cin) : r_c[p];
      w_src_s[k] = (k == 0) ? '0 : r_s[p];
      w_sum[k]   = {1'b0, w_src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, w_src_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, w_src_c[k]};
      w_nxt_s[k] = w_src_s[k];
      w_nxt_s[k][k*CHUNK +: CHUNK] = w_sum[k][CHUNK-1:0];
      w_nxt_c[k] = w_sum[k][CHUNK];
    end
  end

  assign w_ovf  = (w_src_a[LAST][MSB] == w_src_b[LAST][MSB]) &&
                  (w_nxt_s[LAST][MSB] != w_src_a[LAST][MSB]);
  assign w_zero = ~|w_nxt_s[LAST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v    <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= w_src_v[k];
          // Data only moves with a real token so held fields stay put across bubbles.
          if (w_src_v[k]) begin
            r_a[k] <= w_src_a[k];
            r_b[k] <= w_src_b[k];
            r_s[k] <= w_nxt_s[k];
            r_c[k] <= w_nxt_c[k];
          end
        end
      end
      if (w_rdy[LAST] && w_src_v[LAST]) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = r_v[LAST];
  assign bus.S         = r_s[LAST];
  assign bus.Cout      = r_c[LAST];
  assign bus.Ovf       = r_ovf;
  assign bus.Zero      = r_zero;

endmodule
`default_nettype wire
